// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO. It pops lanes through the show-ahead port and packs
// PACK_RATIO lanes into one word. The word goes out on a registered valid/ready stream, and a flush closes a partial word.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep,
    output logic                             m_last,
    output logic                             busy
);

    localparam int CW = $clog2(PACK_RATIO) + 1;
    localparam int WW = DATA_WIDTH * PACK_RATIO;
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic [WW-1:0]         asm_r;
    logic [WW-1:0]         asm_nxt_s;
    logic                  flush_pending_r;
    logic                  flush_pending_nxt_s;
    logic                  m_valid_nxt_s;
    logic                  busy_nxt_s;
    logic                  transfer_s;
    logic                  pop_s;
    logic [CW-1:0]         lane_s;
    logic [PACK_RATIO-1:0] keep_s;
    logic [WW-1:0]         packed_s;

    assign fifo_rd_en = pop_s;

    // Transfer/pop decisions, lane steering and next-state values.
    always_comb begin
        transfer_s = ((count_r == FULL_CNT) || (flush_pending_r && (count_r != ZERO_CNT)))
                     && (!m_valid || m_ready);
        pop_s      = reset_n && !fifo_empty && !flush_pending_r
                     && ((count_r < FULL_CNT) || transfer_s);
        // A pop that coincides with a transfer starts the next word at lane 0.
        lane_s     = transfer_s ? ZERO_CNT : count_r;

        keep_s    = {PACK_RATIO{1'b0}};
        packed_s  = {WW{1'b0}};
        asm_nxt_s = asm_r;
        for (int i = 0; i < PACK_RATIO; i++) begin
            keep_s[i] = (CW'(i) < count_r);
            packed_s[i*DATA_WIDTH +: DATA_WIDTH] = keep_s[i] ? asm_r[i*DATA_WIDTH +: DATA_WIDTH]
                                                             : {DATA_WIDTH{1'b0}};
            asm_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = (pop_s && (lane_s == CW'(i))) ? fifo_rd_data
                                                    : asm_r[i*DATA_WIDTH +: DATA_WIDTH];
        end

        if (transfer_s) begin
            count_nxt_s = pop_s ? ONE_CNT : ZERO_CNT;
        end else if (pop_s) begin
            count_nxt_s = count_r + ONE_CNT;
        end else begin
            count_nxt_s = count_r;
        end

        // A pending flush with nothing assembled simply expires.
        if (flush_pending_r) begin
            flush_pending_nxt_s = !(transfer_s || (count_r == ZERO_CNT));
        end else begin
            flush_pending_nxt_s = flush;
        end

        m_valid_nxt_s = transfer_s || (m_valid && !m_ready);
        busy_nxt_s    = (count_nxt_s != ZERO_CNT) || m_valid_nxt_s || flush_pending_nxt_s;
    end

    // Assembly state, output register and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r         <= ZERO_CNT;
            asm_r           <= {WW{1'b0}};
            flush_pending_r <= 1'b0;
            m_valid         <= 1'b0;
            m_data          <= {WW{1'b0}};
            m_keep          <= {PACK_RATIO{1'b0}};
            m_last          <= 1'b0;
            busy            <= 1'b0;
        end else begin
            count_r         <= count_nxt_s;
            asm_r           <= asm_nxt_s;
            flush_pending_r <= flush_pending_nxt_s;
            m_valid         <= m_valid_nxt_s;
            busy            <= busy_nxt_s;
            if (transfer_s) begin
                m_data <= packed_s;
                m_keep <= keep_s;
                m_last <= flush_pending_r;
            end else begin
                m_data <= m_data;
                m_keep <= m_keep;
                m_last <= m_last;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue-backed show-ahead FIFO model feeds the packer,
// and a beat monitor collects accepted words for comparison with hand-computed values.
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        busy;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  fq[$];
    logic [31:0] bq_data[$];
    logic [3:0]  bq_keep[$];
    logic        bq_last[$];
    logic [7:0]  popped;
    logic        prev_valid = 1'b0;
    int          pops = 0;
    int          underflow = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          rise_cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          base;

    // FIFO pop side and accepted-beat capture, using pre-edge values.
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            if (fq.size() > 0) popped = fq.pop_front();
            else underflow++;
            pops++;
            last_pop_cyc = cyc;
        end
        if (m_valid && m_ready) begin
            bq_data.push_back(m_data);
            bq_keep.push_back(m_keep);
            bq_last.push_back(m_last);
        end
    end

    // Refresh the show-ahead head between edges and note m_valid rising.
    always @(negedge clk) begin
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
        if (m_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = m_valid;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input string tag);
        int k = 0;
        while (pops < target && k < 200) begin
            step(1);
            k++;
        end
        check(tag, 32'(pops >= target), 32'd1);
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l);
        int t = 0;
        while (bq_data.size() == 0 && t < 100) begin
            step(1);
            t++;
        end
        if (bq_data.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_data"}, bq_data.pop_front(), d);
            check({tag, "_keep"}, 32'(bq_keep.pop_front()), 32'(k));
            check({tag, "_last"}, 32'(bq_last.pop_front()), 32'(l));
        end
    endtask

    initial begin
        step(2);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_keep", 32'(m_keep), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reset_n = 1'b1;
        m_ready = 1'b1;
        step(2);

        // Basic pack and output latency
        base = pops;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        wait_pops(base + 4, "t2_pops");
        expect_beat("t2", 32'h44332211, 4'hF, 1'b0);
        check("t2_rise_lat", 32'(rise_cyc), 32'(last_pop_cyc + 1));
        step(2);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // Reset mid-assembly
        base = pops;
        fq.push_back(8'hAA); fq.push_back(8'hBB);
        wait_pops(base + 2, "t1_pops");
        reset_n = 1'b0;
        fq.push_back(8'h5A); fq.push_back(8'h6B); fq.push_back(8'h7C); fq.push_back(8'h8D);
        step(1);
        check("t1_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t1_valid", 32'(m_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_keep", 32'(m_keep), 32'd0);
        check("t1_no_beat", 32'(bq_data.size()), 32'd0);
        reset_n = 1'b1;
        expect_beat("t1", 32'h8D7C6B5A, 4'hF, 1'b0);

        // Backpressure
        m_ready = 1'b0;
        step(1);
        base = pops;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        step(25);
        check("t3_pops", 32'(pops - base), 32'd8);
        check("t3_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t3_valid", 32'(m_valid), 32'd1);
        check("t3_hold0", m_data, 32'h04030201);
        step(5);
        check("t3_hold1", m_data, 32'h04030201);
        check("t3_hold_keep", 32'(m_keep), 32'hF);
        m_ready = 1'b1;
        expect_beat("t3a", 32'h04030201, 4'hF, 1'b0);
        expect_beat("t3b", 32'h08070605, 4'hF, 1'b0);

        // Partial flush, then a single-lane flush
        base = pops;
        fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
        wait_pops(base + 3, "t4_pops");
        flush = 1'b1;
        fq.push_back(8'hD4);
        step(1);
        flush = 1'b0;
        check("t4_no_pop_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        step(1);
        check("t4_no_pop_cnt", 32'(pops - base), 32'd3);
        expect_beat("t4", 32'h00C3B2A1, 4'b0111, 1'b1);
        wait_pops(base + 4, "t4_d4_pop");
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        expect_beat("t4b", 32'h000000D4, 4'b0001, 1'b1);
        step(3);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // Empty flush
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t5_busy_pending", 32'(busy), 32'd1);
        step(2);
        check("t5_busy_clear", 32'(busy), 32'd0);
        check("t5_valid", 32'(m_valid), 32'd0);
        check("t5_no_beat", 32'(bq_data.size()), 32'd0);

        // Flush coincident with the 4th pop, then streaming resumes
        base = pops;
        fq.push_back(8'h10); fq.push_back(8'h20); fq.push_back(8'h30); fq.push_back(8'h40);
        wait_pops(base + 3, "t6_pops");
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t6_4th_pop", 32'(pops - base), 32'd4);
        expect_beat("t6", 32'h40302010, 4'hF, 1'b1);
        fq.push_back(8'h50); fq.push_back(8'h60); fq.push_back(8'h70); fq.push_back(8'h80);
        expect_beat("t6b", 32'h80706050, 4'hF, 1'b0);

        step(3);
        check("no_underflow", 32'(underflow), 32'd0);
        check("final_idle", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
